// File: rtl/axis_fp_add_pipe_if.sv
// Operand/result stream bundle for the pipelined FP adder: two joined operand
// channels (A carries the add/sub sideband) and one result channel with flags.
interface axis_fp_add_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int DW = 1 + EXP_W + FRAC_W;

    logic          s_axis_valid_a;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_op;
    logic          s_axis_ready_a;
    logic          s_axis_valid_b;
    logic [DW-1:0] s_axis_data1;
    logic          s_axis_ready_b;
    logic          m_axis_valid;
    logic [DW-1:0] m_axis_data;
    logic [2:0]    m_axis_flags;
    logic          m_axis_ready;

    modport slave (
        input  s_axis_valid_a, s_axis_data, s_axis_op, s_axis_valid_b, s_axis_data1, m_axis_ready,
        output s_axis_ready_a, s_axis_ready_b, m_axis_valid, m_axis_data, m_axis_flags
    );

    modport master (
        output s_axis_valid_a, s_axis_data, s_axis_op, s_axis_valid_b, s_axis_data1, m_axis_ready,
        input  s_axis_ready_a, s_axis_ready_b, m_axis_valid, m_axis_data, m_axis_flags
    );
endinterface

// File: rtl/axis_fp_add_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise/pack) with a
// joined two-operand AXI-Stream input and a globally stalled pipeline.
module axis_fp_add_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              axis_clk,
    input  logic              axis_reset,
    axis_fp_add_pipe_if.slave axis
);
    localparam int DW   = 1 + EXP_W + FRAC_W;
    localparam int SW   = FRAC_W + 3;          // hidden bit + fraction + 2 guard bits
    localparam int EW   = EXP_W + 2;           // signed exponent with headroom both ways
    localparam int LZ_W = $clog2(SW + 1);
    localparam logic [EXP_W-1:0]    EXP_MAX   = '1;
    localparam logic signed [EW-1:0] EXP_MAX_S = $signed({2'b00, EXP_MAX});
    localparam logic signed [EW-1:0] EXP_ONE_S = EW'(1);

    logic en, accept;
    logic m_valid_reg;

    assign en     = !m_valid_reg || axis.m_axis_ready;
    assign accept = en && axis.s_axis_valid_a && axis.s_axis_valid_b && !axis_reset;
    assign axis.s_axis_ready_a = accept;
    assign axis.s_axis_ready_b = accept;

    // Operand classification; index 1 is B with the subtract folded into its sign
    logic [1:0][DW-1:0]          op_word;
    logic [1:0]                  op_sign, op_zero, op_inf, op_nan;
    logic [1:0][EXP_W-1:0]       op_exp;
    logic [1:0][EXP_W+FRAC_W-1:0] op_mag;
    logic [1:0][SW-1:0]          op_sig;

    assign op_word = {axis.s_axis_data1, axis.s_axis_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            logic [FRAC_W-1:0] frac;
            assign frac        = op_word[gi][FRAC_W-1:0];
            assign op_exp[gi]  = op_word[gi][DW-2 -: EXP_W];
            assign op_sign[gi] = op_word[gi][DW-1] ^ ((gi == 1) && axis.s_axis_op);
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (op_exp[gi] == EXP_MAX) && (frac == '0);
            assign op_nan[gi]  = (op_exp[gi] == EXP_MAX) && (frac != '0);
            assign op_mag[gi]  = op_zero[gi] ? '0 : op_word[gi][DW-2:0];
            assign op_sig[gi]  = op_zero[gi] ? '0 : {1'b1, frac, 2'b00};
        end
    endgenerate

    logic             swap, sign_x, sign_y;
    logic [EXP_W-1:0] exp_x, exp_y, exp_diff;
    logic [SW-1:0]    sig_x, sig_y, sig_y_sh;
    logic             pre_invalid, pre_inf, pre_inf_sign;

    assign swap = op_mag[1] > op_mag[0];

    always_comb begin
        sign_x   = swap ? op_sign[1] : op_sign[0];
        sign_y   = swap ? op_sign[0] : op_sign[1];
        exp_x    = swap ? op_exp[1]  : op_exp[0];
        exp_y    = swap ? op_exp[0]  : op_exp[1];
        sig_x    = swap ? op_sig[1]  : op_sig[0];
        sig_y    = swap ? op_sig[0]  : op_sig[1];
        exp_diff = exp_x - exp_y;
        sig_y_sh = (int'(exp_diff) >= SW) ? '0 : (sig_y >> exp_diff);
    end

    assign pre_invalid  = (|op_nan) || (&op_inf && (op_sign[0] ^ op_sign[1]));
    assign pre_inf      = |op_inf;
    assign pre_inf_sign = op_inf[0] ? op_sign[0] : op_sign[1];

    // Stage registers
    logic             s1_valid_reg, s1_sign_reg, s1_sub_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [SW-1:0]    s1_sig_x_reg, s1_sig_y_reg;
    logic             s1_invalid_reg, s1_inf_reg, s1_inf_sign_reg;
    logic             s2_valid_reg, s2_sign_reg;
    logic [EXP_W-1:0] s2_exp_reg;
    logic [SW:0]      s2_sum_reg;
    logic             s2_invalid_reg, s2_inf_reg, s2_inf_sign_reg;
    logic [DW-1:0]    m_data_reg;
    logic [2:0]       m_flags_reg;

    // X has the larger magnitude, so the difference never goes negative
    logic [SW:0] sum_next;
    assign sum_next = s1_sub_reg ? ({1'b0, s1_sig_x_reg} - {1'b0, s1_sig_y_reg})
                                 : ({1'b0, s1_sig_x_reg} + {1'b0, s1_sig_y_reg});

    logic [LZ_W-1:0] lz;
    always_comb begin
        lz = LZ_W'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s2_sum_reg[i]) lz = LZ_W'(SW - 1 - i);
        end
    end

    logic signed [EW-1:0] exp_n;
    logic [FRAC_W-1:0]    frac_n;
    logic [DW-1:0]        res_data;
    logic [2:0]           res_flags;

    always_comb begin
        if (s2_sum_reg[SW]) begin
            exp_n  = $signed({2'b00, s2_exp_reg}) + EXP_ONE_S;
            frac_n = s2_sum_reg[SW-1:3];
        end else begin
            exp_n  = $signed({2'b00, s2_exp_reg}) - $signed(EW'(lz));
            frac_n = FRAC_W'((s2_sum_reg[SW-1:0] << lz) >> 2);
        end
    end

    always_comb begin
        res_data  = '0;
        res_flags = 3'b000;
        if (s2_invalid_reg) begin
            res_data  = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
            res_flags = 3'b100;
        end else if (s2_inf_reg) begin
            res_data = {s2_inf_sign_reg, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (s2_sum_reg == '0) begin
            res_data = '0;
        end else if (exp_n >= EXP_MAX_S) begin
            res_data  = {s2_sign_reg, EXP_MAX, {FRAC_W{1'b0}}};
            res_flags = 3'b010;
        end else if (exp_n < EXP_ONE_S) begin
            res_data  = {s2_sign_reg, {(DW-1){1'b0}}};
            res_flags = 3'b001;
        end else begin
            res_data = {s2_sign_reg, exp_n[EXP_W-1:0], frac_n};
        end
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            s1_valid_reg    <= 1'b0;
            s1_sign_reg     <= 1'b0;
            s1_sub_reg      <= 1'b0;
            s1_exp_reg      <= '0;
            s1_sig_x_reg    <= '0;
            s1_sig_y_reg    <= '0;
            s1_invalid_reg  <= 1'b0;
            s1_inf_reg      <= 1'b0;
            s1_inf_sign_reg <= 1'b0;
            s2_valid_reg    <= 1'b0;
            s2_sign_reg     <= 1'b0;
            s2_exp_reg      <= '0;
            s2_sum_reg      <= '0;
            s2_invalid_reg  <= 1'b0;
            s2_inf_reg      <= 1'b0;
            s2_inf_sign_reg <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_data_reg      <= '0;
            m_flags_reg     <= 3'b000;
        end else if (en) begin
            s1_valid_reg    <= accept;
            s1_sign_reg     <= sign_x;
            s1_sub_reg      <= sign_x ^ sign_y;
            s1_exp_reg      <= exp_x;
            s1_sig_x_reg    <= sig_x;
            s1_sig_y_reg    <= sig_y_sh;
            s1_invalid_reg  <= pre_invalid;
            s1_inf_reg      <= pre_inf;
            s1_inf_sign_reg <= pre_inf_sign;
            s2_valid_reg    <= s1_valid_reg;
            s2_sign_reg     <= s1_sign_reg;
            s2_exp_reg      <= s1_exp_reg;
            s2_sum_reg      <= sum_next;
            s2_invalid_reg  <= s1_invalid_reg;
            s2_inf_reg      <= s1_inf_reg;
            s2_inf_sign_reg <= s1_inf_sign_reg;
            m_valid_reg     <= s2_valid_reg;
            m_data_reg      <= res_data;
            m_flags_reg     <= res_flags;
        end
    end

    assign axis.m_axis_valid = m_valid_reg;
    assign axis.m_axis_data  = m_data_reg;
    assign axis.m_axis_flags = m_flags_reg;
endmodule

// File: tb/tb_axis_fp_add_pipe.sv
// Bench for axis_fp_add_pipe: directed vectors, lone-valid join, random stream
// with backpressure against a reference model, throughput and mid-stream reset.
module tb_axis_fp_add_pipe;
    logic axis_clk = 1'b0;
    logic axis_reset;
    always #5 axis_clk = ~axis_clk;

    axis_fp_add_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();
    axis_fp_add_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .axis_clk  (axis_clk),
        .axis_reset(axis_reset),
        .axis      (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] d;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic        use_want;
        logic [31:0] want_d;
        logic [2:0]  want_f;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        int          acc_cyc;
    } exp_t;

    localparam int NV = 15;
    vec_t  vecs [NV];
    stim_t stim_q [$];
    exp_t  exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_n = 0;
    int out_n = 0;
    int gap = 0;
    int last_acc_cyc = 0;
    bit rand_ready = 0, rand_gap = 0, check_lat = 0, lone_b_low = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_flags = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: exact significand arithmetic with 2 guard bits, truncation
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic   sa, sb, sx, sy, nan_a, nan_b, inf_a, inf_b;
        int     ea, eb, ex, ey, d, p, e, keya, keyb;
        longint ma, mb, mx, my, sum, n;
        sa = a[31]; sb = b[31] ^ op;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0); inf_a = (ea == 255) && (a[22:0] == 0);
        nan_b = (eb == 255) && (b[22:0] != 0); inf_b = (eb == 255) && (b[22:0] == 0);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) return {3'b100, 32'h7FC00000};
        if (inf_a) return {3'b000, sa, 8'hFF, 23'h0};
        if (inf_b) return {3'b000, sb, 8'hFF, 23'h0};
        ma = (ea == 0) ? 0 : longint'({1'b1, a[22:0]}) * 4;
        mb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]}) * 4;
        keya = (ea == 0) ? 0 : int'(a[30:0]);
        keyb = (eb == 0) ? 0 : int'(b[30:0]);
        if (keyb > keya) begin sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma; end
        else             begin sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb; end
        d = ex - ey;
        my = (d >= 26) ? 0 : (my >> d);
        sum = (sx == sy) ? mx + my : mx - my;
        if (sum == 0) return 35'h0;
        p = 0;
        for (int i = 0; i < 40; i++) if (sum[i]) p = i;
        e = ex + p - 25;
        n = (p >= 25) ? (sum >> (p - 25)) : (sum << (25 - p));
        if (e >= 255) return {3'b010, sx, 8'hFF, 23'h0};
        if (e < 1) return {3'b001, sx, 31'h0};
        return {3'b000, sx, e[7:0], n[24:2]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = int'($urandom_range(15));
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f = f | 23'h1; end
            3:       e = 8'(253 + $urandom_range(1));
            4:       e = 8'(1 + $urandom_range(2));
            default: e = 8'(120 + $urandom_range(15));
        endcase
        return {1'($urandom_range(1)), e, f};
    endfunction

    task automatic push_rand(input int cnt);
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = rand_fp();
            stim_q.push_back('{a, ($urandom_range(7) == 0) ? a : rand_fp(), 1'($urandom_range(1)),
                               1'b0, 32'h0, 3'b000});
        end
    endtask

    task automatic drive();
        if (stim_q.size() > 0 && gap == 0) begin
            bus.s_axis_valid_a = 1'b1;
            bus.s_axis_valid_b = !lone_b_low;
            bus.s_axis_data    = stim_q[0].a;
            bus.s_axis_data1   = stim_q[0].b;
            bus.s_axis_op      = stim_q[0].op;
        end else begin
            bus.s_axis_valid_a = 1'b0;
            bus.s_axis_valid_b = 1'b0;
            if (gap > 0) gap--;
        end
        bus.m_axis_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic tick();
        bit          acc, want_rdy;
        exp_t        e;
        logic [34:0] r;
        acc = 0;
        @(negedge axis_clk);
        if (!axis_reset) begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.m_axis_valid), 64'd1);
                check("hold_data", 64'(bus.m_axis_data), 64'(prev_data));
                check("hold_flags", 64'(bus.m_axis_flags), 64'(prev_flags));
            end
            if (bus.m_axis_valid && bus.m_axis_ready) begin
                out_n++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_output: got data=%h flags=%b, required no output", bus.m_axis_data, bus.m_axis_flags);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", 64'(bus.m_axis_data), 64'(e.data));
                    check("result_flags", 64'(bus.m_axis_flags), 64'(e.flags));
                    if (check_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
                end
            end
            want_rdy = (!bus.m_axis_valid || bus.m_axis_ready) && bus.s_axis_valid_a && bus.s_axis_valid_b;
            check("ready_a", 64'(bus.s_axis_ready_a), 64'(want_rdy));
            check("ready_b", 64'(bus.s_axis_ready_b), 64'(want_rdy));
            acc = bus.s_axis_valid_a && bus.s_axis_valid_b && bus.s_axis_ready_a && bus.s_axis_ready_b;
            if (acc) begin
                if (stim_q[0].use_want) e = '{stim_q[0].want_d, stim_q[0].want_f, cyc};
                else begin
                    r = model(stim_q[0].a, stim_q[0].b, stim_q[0].op);
                    e = '{r[31:0], r[34:32], cyc};
                end
                exp_q.push_back(e);
                acc_n++;
                last_acc_cyc = cyc;
                if (rand_gap) gap = int'($urandom_range(2));
            end
            prev_stall = bus.m_axis_valid && !bus.m_axis_ready;
            prev_data  = bus.m_axis_data;
            prev_flags = bus.m_axis_flags;
        end
        @(posedge axis_clk);
        cyc++;
        #1;
        if (acc) void'(stim_q.pop_front());
        drive();
    endtask

    task automatic run_until(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (out_n < target && n < bound) begin
            tick();
            n++;
        end
        check(name, 64'(out_n), 64'(target));
    endtask

    int base_acc, base_out, start_cyc, n;

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
        vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
        vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
        vecs[5]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001};
        vecs[6]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
        vecs[7]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000};
        vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
        vecs[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
        vecs[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
        vecs[11] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
        vecs[12] = '{32'h3F800000, 32'h4B800000, 1'b0, 32'h4B800000, 3'b000};
        vecs[13] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};
        vecs[14] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000};

        axis_reset         = 1'b1;
        bus.s_axis_valid_a = 1'b1;
        bus.s_axis_valid_b = 1'b1;
        bus.s_axis_data    = 32'h3F800000;
        bus.s_axis_data1   = 32'h3F800000;
        bus.s_axis_op      = 1'b0;
        bus.m_axis_ready   = 1'b1;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check("rst_valid", 64'(bus.m_axis_valid), 64'd0);
        check("rst_data", 64'(bus.m_axis_data), 64'd0);
        check("rst_flags", 64'(bus.m_axis_flags), 64'd0);
        check("rst_ready_a", 64'(bus.s_axis_ready_a), 64'd0);
        check("rst_ready_b", 64'(bus.s_axis_ready_b), 64'd0);
        @(posedge axis_clk);
        #1;
        axis_reset = 1'b0;
        drive();
        tick();
        tick();

        check_lat = 1;
        for (int i = 0; i < NV; i++) begin
            base_out = out_n;
            stim_q.push_back('{vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, vecs[i].d, vecs[i].f});
            drive();
            run_until(base_out + 1, 20, "vector_done");
            tick();
        end

        base_acc = acc_n;
        base_out = out_n;
        lone_b_low = 1;
        stim_q.push_back('{32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, 3'b000});
        drive();
        repeat (5) tick();
        check("lone_no_accept", 64'(acc_n - base_acc), 64'd0);
        check("lone_no_output", 64'(out_n - base_out), 64'd0);
        lone_b_low = 0;
        drive();
        run_until(base_out + 1, 20, "lone_output");
        tick();
        tick();
        check("lone_single_accept", 64'(acc_n - base_acc), 64'd1);
        check("lone_single_output", 64'(out_n - base_out), 64'd1);
        check_lat = 0;

        rand_ready = 1;
        rand_gap = 1;
        base_out = out_n;
        push_rand(16);
        drive();
        run_until(base_out + 16, 400, "rand_stream");
        rand_ready = 0;
        rand_gap = 0;
        gap = 0;
        drive();
        repeat (4) tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        check_lat = 1;
        base_out = out_n;
        push_rand(16);
        drive();
        start_cyc = cyc;
        run_until(base_out + 16, 60, "b2b_stream");
        check("b2b_throughput", 64'(last_acc_cyc - start_cyc), 64'd15);
        check_lat = 0;
        tick();

        base_acc = acc_n;
        push_rand(3);
        drive();
        n = 0;
        while ((acc_n - base_acc) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("pre_reset_accepts", 64'(acc_n - base_acc), 64'd3);
        check("pre_reset_valid", 64'(bus.m_axis_valid), 64'd1);
        #2;
        axis_reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.m_axis_valid), 64'd0);
        check("mid_rst_data", 64'(bus.m_axis_data), 64'd0);
        check("mid_rst_flags", 64'(bus.m_axis_flags), 64'd0);
        exp_q.delete();
        stim_q.delete();
        prev_stall = 1'b0;
        drive();
        repeat (2) @(posedge axis_clk);
        #1;
        axis_reset = 1'b0;
        base_out = out_n;
        repeat (10) tick();
        check("no_stale_output", 64'(out_n - base_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_fp_add_pipe.md
# axis_fp_add_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with AXI4-Stream handshakes on two operand channels and one result channel. It joins one beat from each input stream, performs signed add or subtract, and streams the normalised, packed result with exception flags. Full backpressure is supported: a stalled output freezes the whole pipeline without losing or duplicating data. It sits between the operand AXI-Stream sources and downstream FP consumers in the FP datapath.

## Interface
- EXP_W, 8: exponent field width.
- FRAC_W, 23: stored fraction width (hidden bit implicit); data width DW = 1+EXP_W+FRAC_W.
- axis_clk  in  1  clock; all logic on rising edge.
- axis_reset  in  1  reset, asynchronous, active-high.
- s_axis_valid_a  in  1  operand A valid.
- s_axis_data  in  DW  operand A.
- s_axis_op  in  1  sideband on channel A: 0 = A+B, 1 = A−B.
- s_axis_ready_a  out  1  operand A accepted when high with valid.
- s_axis_valid_b  in  1  operand B valid.
- s_axis_data1  in  DW  operand B.
- s_axis_ready_b  out  1  operand B ready.
- m_axis_valid  out  1  result valid.
- m_axis_data  out  DW  result.
- m_axis_flags  out  3  {invalid, overflow, underflow}, qualified by m_axis_valid.
- m_axis_ready  in  1  downstream ready.

## Operation
- Join: en = !m_axis_valid | m_axis_ready; s_axis_ready_a = s_axis_ready_b = en & s_axis_valid_a & s_axis_valid_b. A beat is accepted only when both channels transfer in the same cycle; a lone valid is never consumed.
- Stage 1 (align): effective B sign = sign_b ^ op. Classify operands (zero: exp=0, any fraction — subnormals flushed to zero; inf: exp all-ones, frac=0; NaN: exp all-ones, frac≠0). Swap so larger magnitude (exp, then frac) is operand X. Shift smaller significand (hidden bit prepended) right by exponent difference; difference ≥ FRAC_W+3 yields zero. Keep 2 guard bits; bits shifted beyond are discarded.
- Stage 2 (add): same effective signs → add magnitudes; different → X − Y (never negative). Result sign = sign of X; exact zero result → +0.
- Stage 3 (normalise/pack): carry out → shift right 1, exp+1. Otherwise leading-zero count shifts left, exp decreases. Rounding is truncation (toward zero); guard bits dropped.
- Exceptions, priority order: any NaN input, or inf − inf → canonical quiet NaN (sign 0, exp all-ones, frac MSB 1 only), invalid=1. Single/same-sign inf → inf of that sign. Exponent reaching all-ones → inf of result sign, overflow=1. Exponent underflows below 1 → ±0 (result sign), underflow=1. Zero from cancellation sets no flag.
- Stall: when en=0, all stage registers and valids hold; data in flight never changes.

## Timing
- Latency 3 cycles accept-to-m_axis_valid with m_axis_ready held high; throughput 1 result/cycle.
- Reset (asynchronous assert, any cycle): all stage valids and m_axis_valid = 0, m_axis_data = 0, m_axis_flags = 0; in-flight operations discarded. s_axis_ready_* low during reset.
- m_axis_data/m_axis_flags stable while m_axis_valid & !m_axis_ready (AXI rule).
- Bubbles (no accept) propagate as invalid stages; a stalled output with empty upper stages still holds accepts off (global enable, no bubble collapsing).
- Simultaneous m_axis_ready rising and new accept in same cycle: both occur; no gap.

## Test plan
- 0x3F800000 + 0x3F800000, op=0 → 0x40000000, flags 000, exactly 3 cycles after accept.
- 0x3FC00000 − 0x3FC00000 (op=1) → 0x00000000, flags 000; 0x3F800000 + 0x33800000 → 0x3F800000 (truncated).
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1; 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1; 0x00800000 − 0x00800001·… pair near min normal → ±0, underflow=1.
- Stream 16 random pairs back-to-back with m_axis_ready toggled pseudo-randomly → results in order, match reference model, none lost/duplicated, data stable during stalls.
- s_axis_valid_a high, s_axis_valid_b low for 5 cycles → no ready asserted, no output; B raised → single accept.
- Assert axis_reset mid-stream with 3 beats in flight → m_axis_valid drops immediately, no stale results after release.
